// File: rtl/tt_mreg_reader_if.sv
// tt_mreg_reader_if: command, accumulator-read and row-output signals of tt_mreg_reader.
interface tt_mreg_reader_if #(
    parameter int VL        = 4,
    parameter int ML        = 4,
    parameter int NUM_MREGS = 2,
    parameter int XLEN      = 64
);
    localparam int MW = $clog2(NUM_MREGS);
    localparam int RW = $clog2(ML);

    logic                   i_cmd_valid;
    logic                   o_cmd_ready;
    logic [MW-1:0]          i_cmd_mreg;
    logic [RW-1:0]          i_cmd_row_start;
    logic [RW:0]            i_cmd_row_cnt;
    logic                   o_cmd_err;
    logic                   o_rd_en;
    logic [MW+RW-1:0]       o_rdaddr;
    logic [VL*XLEN-1:0]     i_rddata;
    logic [NUM_MREGS-1:0]   i_wr_pending;
    logic                   o_row_valid;
    logic                   i_row_ready;
    logic [VL*XLEN-1:0]     o_row_data;
    logic [RW-1:0]          o_row_idx;
    logic                   o_row_last;
    logic                   o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_mreg, i_cmd_row_start, i_cmd_row_cnt, i_rddata, i_wr_pending, i_row_ready,
        output o_cmd_ready, o_cmd_err, o_rd_en, o_rdaddr, o_row_valid, o_row_data, o_row_idx, o_row_last, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_mreg, i_cmd_row_start, i_cmd_row_cnt, i_rddata, i_wr_pending, i_row_ready,
        input  o_cmd_ready, o_cmd_err, o_rd_en, o_rdaddr, o_row_valid, o_row_data, o_row_idx, o_row_last, o_busy
    );
endinterface

// File: rtl/tt_mreg_reader.sv
// tt_mreg_reader: drains a row range of one matrix register into a small row FIFO.
module tt_mreg_reader #(
    parameter int VL         = 4,
    parameter int ML         = 4,
    parameter int NUM_MREGS  = 2,
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    tt_mreg_reader_if.slave   bus
);
    localparam int MW = $clog2(NUM_MREGS);
    localparam int RW = $clog2(ML);
    localparam int DW = VL * XLEN;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [RW+1:0] ML_L = (RW+2)'(ML);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          r_state, w_next;
    logic [MW-1:0]   r_mreg;
    logic [RW-1:0]   r_row;
    logic [RW:0]     r_left;
    logic            r_cmd_err;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [RW-1:0]   r_fifo_idx  [FIFO_DEPTH];
    logic            r_fifo_last [FIFO_DEPTH];

    logic w_accept, w_legal, w_push, w_pop, w_last_row, w_valid;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_accept   = bus.i_cmd_valid && (r_state == IDLE);
    assign w_legal    = (bus.i_cmd_row_cnt != '0) &&
                        ((RW+2)'(bus.i_cmd_row_start) + (RW+2)'(bus.i_cmd_row_cnt) <= ML_L);
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && bus.i_row_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a row.
    assign w_push     = (r_state == READ) && !bus.i_wr_pending[r_mreg] &&
                        ((r_count != CW'(FIFO_DEPTH)) || w_pop);
    assign w_last_row = (r_left == (RW+1)'(1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept && w_legal) w_next = READ;
            READ:    if (w_push && w_last_row) w_next = DRAIN;
            DRAIN:   if (!w_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_mreg    <= '0;
            r_row     <= '0;
            r_left    <= '0;
            r_cmd_err <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_cmd_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_mreg <= bus.i_cmd_mreg;
                r_row  <= bus.i_cmd_row_start;
                r_left <= bus.i_cmd_row_cnt;
            end else if (w_push) begin
                r_row  <= r_row + RW'(1);
                r_left <= r_left - (RW+1)'(1);
            end
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop) r_rptr <= f_inc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= bus.i_rddata;
            r_fifo_idx[r_wptr]  <= r_row;
            r_fifo_last[r_wptr] <= w_last_row;
        end
    end

    assign bus.o_cmd_ready = (r_state == IDLE);
    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_cmd_err   = r_cmd_err;
    assign bus.o_rd_en     = w_push;
    assign bus.o_rdaddr    = w_push ? {r_mreg, r_row} : '0;
    assign bus.o_row_valid = w_valid;
    assign bus.o_row_data  = w_valid ? r_fifo_data[r_rptr] : '0;
    assign bus.o_row_idx   = w_valid ? r_fifo_idx[r_rptr] : '0;
    assign bus.o_row_last  = w_valid && r_fifo_last[r_rptr];
endmodule

// File: tb/tb_tt_mreg_reader.sv
// tb_tt_mreg_reader: directed and randomized drain commands checked against a row-level scoreboard.
module tb_tt_mreg_reader;
    localparam int VL = 4, ML = 4, NUM_MREGS = 2, XLEN = 64, FIFO_DEPTH = 2;
    localparam int MW = $clog2(NUM_MREGS);
    localparam int RW = $clog2(ML);
    localparam int DW = VL * XLEN;
    localparam int AW = MW + RW;
    localparam int CW = DW + 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] idx;
        logic          last;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_mreg_reader_if #(.VL(VL), .ML(ML), .NUM_MREGS(NUM_MREGS), .XLEN(XLEN)) bus();

    tt_mreg_reader #(.VL(VL), .ML(ML), .NUM_MREGS(NUM_MREGS), .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] rmem [NUM_MREGS*ML];
    assign bus.i_rddata = rmem[bus.o_rdaddr];

    row_t          exp_rows[$];
    logic [AW-1:0] exp_rd[$];
    int  n_asserts = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  cur_mreg = 0;
    bit  prev_stall = 1'b0;
    row_t prev_row;
    int  s_busy, s_rd, s_rd_first, s_rd_last, s_pops, s_pop_first, s_pop_last;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a legal command reads rows start..start+cnt-1 of its mreg in order.
    task automatic expect_cmd(input int mreg, input int start, input int cnt);
        if (cnt != 0 && start + cnt <= ML) begin
            for (int r = start; r < start + cnt; r++) begin
                exp_rd.push_back(AW'(mreg * ML + r));
                exp_rows.push_back('{data: rmem[mreg * ML + r], idx: RW'(r), last: (r == start + cnt - 1)});
            end
        end
    endtask

    task automatic send_cmd(input int mreg, input int start, input int cnt, output bit legal);
        int w = 0;
        tick();
        legal = (cnt != 0) && (start + cnt <= ML);
        bus.i_cmd_valid     = 1'b1;
        bus.i_cmd_mreg      = MW'(mreg);
        bus.i_cmd_row_start = RW'(start);
        bus.i_cmd_row_cnt   = (RW+1)'(cnt);
        cur_mreg = mreg;
        expect_cmd(mreg, start, cnt);
        forever begin
            @(negedge clk);
            if (bus.o_cmd_ready) break;
            w++;
            if (w > 200) begin
                chk("cmd_ready_timeout", bus.o_cmd_ready, 1);
                break;
            end
            @(posedge clk);
        end
        tick();
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic run(input bit rnd, input bit legal);
        int k = 0;
        s_busy = 0; s_rd = 0; s_rd_first = -1; s_rd_last = -1;
        s_pops = 0; s_pop_first = -1; s_pop_last = -1;
        forever begin
            if (rnd) begin
                bus.i_row_ready  = ($urandom_range(0, 3) != 0);
                bus.i_wr_pending = ($urandom_range(0, 3) == 0) ? NUM_MREGS'($urandom) : '0;
            end
            @(negedge clk);
            if (k == 0) chk("cmd_err", bus.o_cmd_err, !legal);
            if (bus.o_busy) s_busy++;
            if (bus.o_rd_en) begin
                s_rd++;
                if (s_rd_first < 0) s_rd_first = k;
                s_rd_last = k;
            end
            if (bus.o_row_valid && bus.i_row_ready) begin
                s_pops++;
                if (s_pop_first < 0) s_pop_first = k;
                s_pop_last = k;
            end
            if (!bus.o_busy) break;
            k++;
            if (k > 400) begin
                chk("drain_timeout", bus.o_busy, 0);
                break;
            end
            tick();
        end
    endtask

    task automatic cycles(input int n, output int rd);
        rd = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.o_rd_en) rd++;
            tick();
        end
    endtask

    task automatic monitor();
        row_t e;
        if (!rst_n || !mon_en) begin
            prev_stall = 1'b0;
            return;
        end
        chk("ready_vs_busy", bus.o_cmd_ready, !bus.o_busy);
        if (bus.o_busy && bus.i_wr_pending[cur_mreg]) chk("stall_rd_en", bus.o_rd_en, 0);
        if (bus.o_rd_en) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", bus.o_rd_en, 0);
            else chk("rdaddr", bus.o_rdaddr, exp_rd.pop_front());
        end else begin
            chk("rdaddr_idle", bus.o_rdaddr, 0);
        end
        if (prev_stall) begin
            chk("hold_valid", bus.o_row_valid, 1);
            chk("hold_row", {bus.o_row_data, bus.o_row_idx, bus.o_row_last}, prev_row);
        end
        if (bus.o_row_valid && bus.i_row_ready) begin
            if (exp_rows.size() == 0) begin
                chk("row_unexpected", bus.o_row_valid, 0);
            end else begin
                e = exp_rows.pop_front();
                chk("row_data", bus.o_row_data, e.data);
                chk("row_idx", bus.o_row_idx, e.idx);
                chk("row_last", bus.o_row_last, e.last);
            end
        end
        prev_stall = bus.o_row_valid && !bus.i_row_ready;
        prev_row   = {bus.o_row_data, bus.o_row_idx, bus.o_row_last};
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    initial begin
        bit legal;
        int rd;
        for (int a = 0; a < NUM_MREGS * ML; a++)
            for (int k = 0; k < VL; k++)
                rmem[a][k*XLEN +: XLEN] = (a / ML == 1) ? XLEN'(16 + a % ML) : XLEN'({$urandom, $urandom});
        bus.i_cmd_valid = 1'b0; bus.i_cmd_mreg = '0; bus.i_cmd_row_start = '0; bus.i_cmd_row_cnt = '0;
        bus.i_wr_pending = '0; bus.i_row_ready = 1'b1;

        // Reset values
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.o_cmd_ready, 1);
        chk("rst_cmd_err", bus.o_cmd_err, 0);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_rdaddr", bus.o_rdaddr, 0);
        chk("rst_row_valid", bus.o_row_valid, 0);
        chk("rst_row_data", bus.o_row_data, 0);
        chk("rst_row_idx", bus.o_row_idx, 0);
        chk("rst_row_last", bus.o_row_last, 0);
        chk("rst_busy", bus.o_busy, 0);
        mon_en = 1'b1;

        // Full drain of mreg 1 with consumer always ready
        send_cmd(1, 0, 4, legal);
        run(0, legal);
        chk("full_busy", s_busy, 6);
        chk("full_reads", s_rd, 4);
        chk("full_rd_span", s_rd_last - s_rd_first, 3);
        chk("full_pops", s_pops, 4);
        chk("full_pop_span", s_pop_last - s_pop_first, 3);
        chk("full_sb_empty", exp_rows.size() + exp_rd.size(), 0);

        // Backpressure: only FIFO_DEPTH reads before stalling
        bus.i_row_ready = 1'b0;
        send_cmd(0, 0, 4, legal);
        cycles(6, rd);
        chk("bp_reads_stalled", rd, FIFO_DEPTH);
        bus.i_row_ready = 1'b1;
        run(0, legal);
        chk("bp_reads_rest", s_rd, 4 - FIFO_DEPTH);
        chk("bp_sb_empty", exp_rows.size() + exp_rd.size(), 0);

        // Illegal commands
        send_cmd(0, 3, 2, legal);
        @(negedge clk);
        chk("ill_range_err", bus.o_cmd_err, 1);
        chk("ill_range_rd", bus.o_rd_en, 0);
        chk("ill_range_ready", bus.o_cmd_ready, 1);
        tick();
        @(negedge clk);
        chk("ill_range_err_pulse", bus.o_cmd_err, 0);
        chk("ill_range_rd2", bus.o_rd_en, 0);
        send_cmd(1, 1, 0, legal);
        @(negedge clk);
        chk("ill_zero_err", bus.o_cmd_err, 1);
        chk("ill_zero_ready", bus.o_cmd_ready, 1);
        tick();
        @(negedge clk);
        chk("ill_zero_err_pulse", bus.o_cmd_err, 0);

        // Write-pending stall on own mreg, ignored on other mreg
        bus.i_wr_pending = 2'b01;
        send_cmd(0, 0, 4, legal);
        cycles(3, rd);
        chk("pend_stall_reads", rd, 0);
        bus.i_wr_pending = 2'b00;
        run(0, legal);
        chk("pend_after_reads", s_rd, 4);
        bus.i_wr_pending = 2'b10;
        send_cmd(0, 0, 4, legal);
        run(0, legal);
        chk("pend_other_reads", s_rd, 4);
        chk("pend_other_span", s_rd_last - s_rd_first, 3);
        chk("pend_other_busy", s_busy, 6);
        bus.i_wr_pending = 2'b00;

        // Reset mid-command discards buffered rows
        bus.i_row_ready = 1'b0;
        send_cmd(1, 0, 4, legal);
        cycles(2, rd);
        chk("mid_rst_reads", rd, 2);
        rst_n = 1'b0;
        exp_rows.delete();
        exp_rd.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.o_row_valid, 0);
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_ready", bus.o_cmd_ready, 1);
        bus.i_row_ready = 1'b1;
        send_cmd(0, 1, 3, legal);
        run(0, legal);
        chk("mid_rst_new_reads", s_rd, 3);
        chk("mid_rst_sb_empty", exp_rows.size() + exp_rd.size(), 0);

        // Single row at index 2
        send_cmd(0, 2, 1, legal);
        run(0, legal);
        chk("single_reads", s_rd, 1);
        chk("single_pops", s_pops, 1);
        chk("single_busy", s_busy, 3);
        chk("single_sb_empty", exp_rows.size() + exp_rd.size(), 0);

        // Randomized commands with random backpressure and pending flags
        repeat (40) begin
            send_cmd($urandom_range(0, NUM_MREGS - 1), $urandom_range(0, ML - 1), $urandom_range(0, ML), legal);
            run(1, legal);
            chk("rand_sb_empty", exp_rows.size() + exp_rd.size(), 0);
        end
        bus.i_row_ready = 1'b1;
        bus.i_wr_pending = '0;

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
